// File: rtl/z80_io_bridge.sv
// I/O and data-bus bridge for the tv80 Z80 system: decodes the 8-bit I/O space into
// UART, latched output ports and synchronised input ports, muxes CPU read data, adds wait states.
module z80_io_bridge #(
    parameter int         NUM_OUT   = 4,
    parameter int         NUM_IN    = 2,
    parameter logic [7:0] OUT_BASE  = 8'hB8,
    parameter logic [7:0] IN_BASE   = 8'hC0,
    parameter logic [7:0] UART_BASE = 8'h00,
    parameter int         UART_SIZE = 8,
    parameter int         IO_WAIT   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            address,
    input  logic [7:0]             dbus_out,
    input  logic                   rd_n,
    input  logic                   wr_n,
    input  logic                   mreq_n,
    input  logic                   iorq_n,
    input  logic                   m1_n,
    input  logic [7:0]             mem_dout,
    input  logic [7:0]             uart_dout,
    input  logic [8*NUM_IN-1:0]    in_ports,
    output logic [7:0]             dbus_in,
    output logic                   wait_n,
    output logic                   uart_enable,
    output logic [8*NUM_OUT-1:0]   out_ports,
    output logic [NUM_OUT-1:0]     out_strobe
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic                io_cyc;
    logic                inta;
    logic                io_wr;
    logic                io_wr_q;
    logic [7:0]          io_addr;
    logic [NUM_OUT-1:0]  out_sel;
    logic [NUM_IN-1:0]   in_sel;
    logic                uart_hit;
    logic [7:0]          out_data;
    logic [7:0]          in_data;
    logic [8*NUM_IN-1:0] sync1;
    logic [8*NUM_IN-1:0] sync2;
    logic [1:0]          state;
    logic [3:0]          cnt;
    logic                unused_bits;

    // Only the low address byte is decoded for I/O; rd_n is implied by the mux selection.
    assign unused_bits = ^{address[15:8], rd_n};

    assign io_addr = address[7:0];
    assign io_cyc  = !iorq_n && m1_n;
    assign inta    = !iorq_n && !m1_n;
    assign io_wr   = io_cyc && !wr_n;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        out_sel  = '0;
        in_sel   = '0;
        out_data = 8'h00;
        in_data  = 8'h00;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (int'(io_addr) == int'(OUT_BASE) + k) begin
                out_sel[k] = 1'b1;
                out_data   = out_ports[8*k +: 8];
            end
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(io_addr) == int'(IN_BASE) + k) begin
                in_sel[k] = 1'b1;
                in_data   = sync2[8*k +: 8];
            end
        end
        uart_hit = (int'(io_addr) >= int'(UART_BASE)) &&
                   (int'(io_addr) <  int'(UART_BASE) + UART_SIZE);
    end

    assign uart_enable = io_cyc && uart_hit;

    always_comb begin
        dbus_in = mem_dout;
        if (!mreq_n) begin
            dbus_in = mem_dout;
        end else if (inta) begin
            dbus_in = 8'hFF;                       // RST 38h vector
        end else if (io_cyc) begin
            if (|out_sel)      dbus_in = out_data;
            else if (|in_sel)  dbus_in = in_data;
            else if (uart_hit) dbus_in = uart_dout;
            else               dbus_in = 8'hFF;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    // io_wr_q resets high so a write already in progress at reset release is never committed.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_ports  <= '0;
            out_strobe <= '0;
            io_wr_q    <= 1'b1;
        end else begin
            io_wr_q    <= io_wr;
            out_strobe <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                if (io_wr && !io_wr_q && out_sel[k]) begin
                    out_ports[8*k +: 8] <= dbus_out;
                    out_strobe[k]       <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_ports;
            sync2 <= sync1;
        end
    end

    // Wait-state generator: one burst per I/O cycle, re-armed only once iorq_n is seen high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            wait_n <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (io_cyc) begin
                        if (IO_WAIT > 0) begin
                            state  <= ST_WAIT;
                            cnt    <= 4'(IO_WAIT - 1);
                            wait_n <= 1'b0;
                        end else begin
                            state  <= ST_HOLD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state  <= ST_HOLD;
                        wait_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (iorq_n) state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    wait_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
